// File: rtl/mips_debug_controller.sv
// mips_debug_controller
// UART-driven sequencer for the 5-stage MIPS pipeline. It decodes command
// bytes ('L' load, 'C' continue, 'S' step, 'R' reset). It drives the pipeline
// enable, reset and instruction-memory write ports. After a run or step it
// streams a 136-byte state dump (PC, cycle count, 32 GPRs) back over the UART.
//
// Handshakes:
//   Rx_Valid is a one-cycle strobe with no back-pressure. A byte is consumed
//   only in IDLE, LOAD_CNT and LOAD_BYTE. In any other state it is dropped.
//   Tx_Start is a one-cycle strobe, raised only while Tx_Busy is low. Tx_Data
//   is valid in that same cycle. Tx_Busy only rises the cycle after Tx_Start,
//   so each *_WAIT state ignores Tx_Busy for one cycle. It then waits for
//   Tx_Busy to be low before moving on.
module mips_debug_controller #(
    parameter int IM_ADDR_WIDTH = 10,
    parameter int RUN_TIMEOUT   = 65535,
    parameter int N_REGS        = 32
) (
    input  logic                     ClockIn,
    input  logic                     Reset,
    input  logic [7:0]               Rx_Data,
    input  logic                     Rx_Valid,
    input  logic                     Tx_Busy,
    output logic [7:0]               Tx_Data,
    output logic                     Tx_Start,
    input  logic                     Halt,
    input  logic [31:0]              PC_In,
    input  logic [31:0]              Dbg_RegData,
    output logic [4:0]               Dbg_RegAddr,
    output logic                     CPU_Enable,
    output logic                     CPU_Reset,
    output logic                     IM_WriteEnable,
    output logic [IM_ADDR_WIDTH-1:0] IM_Address,
    output logic [31:0]              IM_WriteData,
    output logic [3:0]               dbg_state
);

    // Last byte index of the dump: two header words plus one word per GPR.
    localparam logic [7:0] DUMP_LAST = 8'(8 + 4 * N_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD_CNT  = 4'd1,
        S_LOAD_BYTE = 4'd2,
        S_LOAD_WR   = 4'd3,
        S_RUN       = 4'd4,
        S_STEP      = 4'd5,
        S_DUMP_SEND = 4'd6,
        S_DUMP_WAIT = 4'd7,
        S_ACK_SEND  = 4'd8,
        S_ACK_WAIT  = 4'd9,
        S_CPU_RST   = 4'd10
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] cnt_inc;
    logic [31:0] run_cnt;
    logic        run_done;
    logic [31:0] pc_lat;
    logic [31:0] cnt_lat;
    logic [7:0]  word_n;
    logic [7:0]  word_idx;
    logic [1:0]  byte_cnt;
    logic [7:0]  dump_idx;
    logic        wait_skip;
    logic [31:0] dump_word;
    logic [7:0]  dump_byte;

    // Saturating +1 of the cycle counter, and the run-local timeout condition.
    assign cnt_inc   = (cycle_cnt == 32'hFFFF_FFFF) ? cycle_cnt : cycle_cnt + 32'd1;
    assign run_done  = (run_cnt + 32'd1) == 32'(RUN_TIMEOUT);
    assign dbg_state = state;

    // Word index wraps naturally at the instruction-memory address width.
    assign IM_Address = IM_ADDR_WIDTH'({word_idx, 2'b00});

    // Select the dump byte for the current index, MSB first within each word.
    always_comb begin
        dump_word = Dbg_RegData;
        if (dump_idx[7:2] == 6'd0) begin
            dump_word = pc_lat;
        end else if (dump_idx[7:2] == 6'd1) begin
            dump_word = cnt_lat;
        end
        case (dump_idx[1:0])
            2'd0:    dump_byte = dump_word[31:24];
            2'd1:    dump_byte = dump_word[23:16];
            2'd2:    dump_byte = dump_word[15:8];
            default: dump_byte = dump_word[7:0];
        endcase
    end

    // State register.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and all strobe/handshake outputs.
    always_comb begin
        state_nxt      = state;
        Tx_Start       = 1'b0;
        Tx_Data        = 8'h00;
        Dbg_RegAddr    = 5'd0;
        CPU_Enable     = 1'b0;
        CPU_Reset      = 1'b0;
        IM_WriteEnable = 1'b0;
        case (state)
            S_IDLE: begin
                if (Rx_Valid) begin
                    case (Rx_Data)
                        8'h4C:   state_nxt = S_LOAD_CNT;
                        8'h43:   state_nxt = halted ? S_DUMP_SEND : S_RUN;
                        8'h53:   state_nxt = halted ? S_DUMP_SEND : S_STEP;
                        8'h52:   state_nxt = S_CPU_RST;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_LOAD_CNT: begin
                if (Rx_Valid) begin
                    state_nxt = (Rx_Data == 8'h00) ? S_ACK_SEND : S_LOAD_BYTE;
                end
            end
            S_LOAD_BYTE: begin
                if (Rx_Valid && byte_cnt == 2'd3) begin
                    state_nxt = S_LOAD_WR;
                end
            end
            S_LOAD_WR: begin
                IM_WriteEnable = 1'b1;
                state_nxt = ((word_idx + 8'd1) == word_n) ? S_ACK_SEND : S_LOAD_BYTE;
            end
            S_RUN: begin
                CPU_Enable = 1'b1;
                if (Halt || run_done) begin
                    state_nxt = S_DUMP_SEND;
                end
            end
            S_STEP: begin
                CPU_Enable = 1'b1;
                state_nxt  = S_DUMP_SEND;
            end
            S_CPU_RST: begin
                CPU_Reset = 1'b1;
                state_nxt = S_ACK_SEND;
            end
            S_DUMP_SEND: begin
                Tx_Data = dump_byte;
                if (dump_idx >= 8'd8) Dbg_RegAddr = dump_idx[6:2] - 5'd2;
                if (!Tx_Busy) begin
                    Tx_Start  = 1'b1;
                    state_nxt = S_DUMP_WAIT;
                end
            end
            S_DUMP_WAIT: begin
                Tx_Data = dump_byte;
                if (dump_idx >= 8'd8) Dbg_RegAddr = dump_idx[6:2] - 5'd2;
                if (!wait_skip && !Tx_Busy) begin
                    state_nxt = (dump_idx == DUMP_LAST) ? S_IDLE : S_DUMP_SEND;
                end
            end
            S_ACK_SEND: begin
                Tx_Data = 8'h4B;
                if (!Tx_Busy) begin
                    Tx_Start  = 1'b1;
                    state_nxt = S_ACK_WAIT;
                end
            end
            S_ACK_WAIT: begin
                Tx_Data = 8'h4B;
                if (!wait_skip && !Tx_Busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load assembly, cycle/run counters, halted flag, dump latches.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            halted       <= 1'b0;
            cycle_cnt    <= 32'd0;
            run_cnt      <= 32'd0;
            pc_lat       <= 32'd0;
            cnt_lat      <= 32'd0;
            word_n       <= 8'd0;
            word_idx     <= 8'd0;
            byte_cnt     <= 2'd0;
            dump_idx     <= 8'd0;
            wait_skip    <= 1'b0;
            IM_WriteData <= 32'd0;
        end else begin
            // The last cycle of a SEND state arms the skip for the WAIT state.
            wait_skip <= (state == S_DUMP_SEND) || (state == S_ACK_SEND);

            if (state == S_IDLE) run_cnt <= 32'd0;
            if (state == S_RUN)  run_cnt <= run_cnt + 32'd1;

            if (state == S_LOAD_CNT && Rx_Valid) begin
                word_n   <= Rx_Data;
                word_idx <= 8'd0;
                byte_cnt <= 2'd0;
            end
            if (state == S_LOAD_BYTE && Rx_Valid) begin
                IM_WriteData <= {IM_WriteData[23:0], Rx_Data};
                byte_cnt     <= byte_cnt + 2'd1;
            end
            if (state == S_LOAD_WR) word_idx <= word_idx + 8'd1;

            if (CPU_Enable) begin
                cycle_cnt <= cnt_inc;
                if (Halt) halted <= 1'b1;
            end
            if (CPU_Reset) begin
                cycle_cnt <= 32'd0;
                halted    <= 1'b0;
            end

            // Freeze PC and count on dump entry so the streamed values are stable.
            if (state_nxt == S_DUMP_SEND && state != S_DUMP_SEND && state != S_DUMP_WAIT) begin
                pc_lat   <= PC_In;
                cnt_lat  <= CPU_Enable ? cnt_inc : cycle_cnt;
                dump_idx <= 8'd0;
            end else if (state == S_DUMP_WAIT && state_nxt == S_DUMP_SEND) begin
                dump_idx <= dump_idx + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_debug_controller.sv
// Bench for mips_debug_controller: directed test-plan scenarios plus random
// command streams, checked against a transaction-level model of the controller.
module tb_mips_debug_controller;

    localparam int AW  = 10;
    localparam int TMO = 16;

    logic          ClockIn = 1'b0;
    logic          Reset;
    logic [7:0]    Rx_Data;
    logic          Rx_Valid;
    logic          Tx_Busy;
    logic [7:0]    Tx_Data;
    logic          Tx_Start;
    logic          Halt;
    logic [31:0]   PC_In;
    logic [31:0]   Dbg_RegData;
    logic [4:0]    Dbg_RegAddr;
    logic          CPU_Enable;
    logic          CPU_Reset;
    logic          IM_WriteEnable;
    logic [AW-1:0] IM_Address;
    logic [31:0]   IM_WriteData;
    logic [3:0]    dbg_state;

    // Clock and reset-free infrastructure.
    always #5 ClockIn = ~ClockIn;

    mips_debug_controller #(
        .IM_ADDR_WIDTH(AW),
        .RUN_TIMEOUT  (TMO),
        .N_REGS       (32)
    ) dut (
        .ClockIn        (ClockIn),
        .Reset          (Reset),
        .Rx_Data        (Rx_Data),
        .Rx_Valid       (Rx_Valid),
        .Tx_Busy        (Tx_Busy),
        .Tx_Data        (Tx_Data),
        .Tx_Start       (Tx_Start),
        .Halt           (Halt),
        .PC_In          (PC_In),
        .Dbg_RegData    (Dbg_RegData),
        .Dbg_RegAddr    (Dbg_RegAddr),
        .CPU_Enable     (CPU_Enable),
        .CPU_Reset      (CPU_Reset),
        .IM_WriteEnable (IM_WriteEnable),
        .IM_Address     (IM_Address),
        .IM_WriteData   (IM_WriteData),
        .dbg_state      (dbg_state)
    );

    // Environment: register file, PC source, UART TX busy, halting CPU.
    logic [31:0] gpr [32];
    logic [31:0] pc_base  = 32'd0;
    logic [31:0] pc_noise = 32'd0;
    int          busy_cnt = 0;
    int          en_total = 0;
    int          rst_total = 0;
    int          en_start = 0;
    int          rst_start = 0;
    int          halt_at = 0;
    int          tx_base = 0;
    int          im_base = 0;

    assign Dbg_RegData = gpr[Dbg_RegAddr];
    assign PC_In       = pc_base ^ pc_noise;
    assign Tx_Busy     = (busy_cnt != 0);
    assign Halt        = CPU_Enable && (halt_at != 0) && ((en_total - en_start) == halt_at - 1);

    always @(posedge ClockIn) begin
        if (Tx_Start) busy_cnt <= $urandom_range(1, 4);
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (CPU_Enable) en_total <= en_total + 1;
    end

    // Scoreboard: expected queues and observed logs.
    logic [7:0]     exp_tx[$];
    logic [AW+31:0] exp_im[$];
    logic [7:0]     tx_log[$];
    logic [AW+31:0] im_log[$];
    int             n_tests = 0;
    int             n_fail  = 0;

    // Model state.
    logic [31:0] m_cnt    = 32'd0;
    bit          m_halted = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every Tx byte and IM write against the expected queues.
    always @(negedge ClockIn) begin
        if (Tx_Start) begin
            tx_log.push_back(Tx_Data);
            if (exp_tx.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got %02h expected no byte", Tx_Data);
            end else begin
                check("tx_byte", Tx_Data, exp_tx.pop_front());
            end
            pc_noise = $urandom;
        end
        if (IM_WriteEnable) begin
            im_log.push_back({IM_Address, IM_WriteData});
            if (exp_im.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL im_unexpected: got %0h expected no write", {IM_Address, IM_WriteData});
            end else begin
                check("im_write", {IM_Address, IM_WriteData}, exp_im.pop_front());
            end
        end
        if (CPU_Enable || IM_WriteEnable) check("enable_write_exclusive", CPU_Enable & IM_WriteEnable, 0);
        if (CPU_Reset) rst_total++;
    end

    function automatic logic [31:0] sat_add(logic [31:0] a, int n);
        logic [32:0] s;
        s = {1'b0, a} + 33'(n);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic void push_dump(logic [31:0] pc, logic [31:0] cnt);
        logic [31:0] w;
        logic [31:0] sh;
        for (int b = 0; b < 136; b++) begin
            if (b < 4) w = pc;
            else if (b < 8) w = cnt;
            else w = gpr[b / 4 - 2];
            sh = w >> (8 * (3 - b % 4));
            exp_tx.push_back(sh[7:0]);
        end
    endfunction

    // Driver tasks.
    task automatic idle(input int n);
        repeat (n) @(negedge ClockIn);
    endtask

    task automatic send_byte(input logic [7:0] b);
        Rx_Data  = b;
        Rx_Valid = 1'b1;
        @(negedge ClockIn);
        Rx_Valid = 1'b0;
        Rx_Data  = 8'($urandom);
        idle($urandom_range(1, 3));
    endtask

    task automatic begin_cmd(input int h);
        en_start  = en_total;
        rst_start = rst_total;
        tx_base   = tx_log.size();
        im_base   = im_log.size();
        halt_at   = h;
        gpr[0]    = 32'd0;
        for (int i = 1; i < 32; i++) gpr[i] = $urandom;
        pc_base   = $urandom;
    endtask

    task automatic wait_done(input bit inject);
        int  guard;
        bit  injected;
        guard    = 0;
        injected = 1'b0;
        while ((exp_tx.size() != 0 || exp_im.size() != 0) && guard < 5000) begin
            @(negedge ClockIn);
            guard++;
            if (inject && !injected && exp_tx.size() > 20 && exp_tx.size() < 100) begin
                case ($urandom_range(0, 3))
                    0:       Rx_Data = 8'h4C;
                    1:       Rx_Data = 8'h43;
                    2:       Rx_Data = 8'h53;
                    default: Rx_Data = 8'h52;
                endcase
                Rx_Valid = 1'b1;
                @(negedge ClockIn);
                Rx_Valid = 1'b0;
                injected = 1'b1;
                guard++;
            end
        end
        if (guard >= 5000) check("wait_timeout", exp_tx.size() + exp_im.size(), 0);
        idle(2);
        guard = 0;
        while (Tx_Busy && guard < 50) begin
            @(negedge ClockIn);
            guard++;
        end
        if (guard >= 50) check("tx_busy_timeout", Tx_Busy, 0);
        idle(2);
    endtask

    task automatic end_cmd(input int exp_en, input int exp_rst);
        check("enable_cycles", en_total - en_start, exp_en);
        check("cpu_reset_pulses", rst_total - rst_start, exp_rst);
    endtask

    // Model for C/S/R/other commands: enables, counter, halted, expected bytes.
    task automatic do_cmd(input logic [7:0] c, input int h, input bit inject);
        int n;
        int exp_en;
        int exp_rst;
        begin_cmd(h);
        exp_en  = 0;
        exp_rst = 0;
        if (c == 8'h43) begin
            if (!m_halted) begin
                n = (h >= 1 && h <= TMO) ? h : TMO;
                exp_en = n;
                m_cnt  = sat_add(m_cnt, n);
                if (h >= 1 && h <= TMO) m_halted = 1'b1;
            end
            push_dump(pc_base ^ pc_noise, m_cnt);
        end else if (c == 8'h53) begin
            if (!m_halted) begin
                exp_en = 1;
                m_cnt  = sat_add(m_cnt, 1);
                if (h == 1) m_halted = 1'b1;
            end
            push_dump(pc_base ^ pc_noise, m_cnt);
        end else if (c == 8'h52) begin
            exp_rst  = 1;
            m_cnt    = 32'd0;
            m_halted = 1'b0;
            exp_tx.push_back(8'h4B);
        end
        send_byte(c);
        wait_done(inject);
        end_cmd(exp_en, exp_rst);
    endtask

    task automatic do_load(input int n, input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] words [3];
        logic [31:0] sh;
        words = '{w0, w1, w2};
        begin_cmd(0);
        for (int i = 0; i < n; i++) exp_im.push_back({AW'(i * 4), words[i]});
        exp_tx.push_back(8'h4B);
        send_byte(8'h4C);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                sh = words[i] >> (8 * (3 - k));
                send_byte(sh[7:0]);
            end
        end
        wait_done(1'b0);
        end_cmd(0, 0);
    endtask

    task automatic check_count_field(input logic [31:0] v);
        logic [31:0] sh;
        for (int i = 0; i < 4; i++) begin
            sh = v >> (8 * (3 - i));
            check("dump_count_byte", tx_log[tx_base + 4 + i], sh[7:0]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_start"}, Tx_Start, 0);
        check({tag, "_tx_data"}, Tx_Data, 0);
        check({tag, "_dbg_regaddr"}, Dbg_RegAddr, 0);
        check({tag, "_cpu_enable"}, CPU_Enable, 0);
        check({tag, "_cpu_reset"}, CPU_Reset, 0);
        check({tag, "_im_we"}, IM_WriteEnable, 0);
        check({tag, "_im_addr"}, IM_Address, 0);
        check({tag, "_im_wdata"}, IM_WriteData, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int g;
        Reset    = 1'b1;
        Rx_Data  = 8'h00;
        Rx_Valid = 1'b0;
        for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
        idle(3);
        check_idle_outputs("reset");
        Reset = 1'b0;
        idle(2);

        // Two-word load, pinned to hand-computed addresses and data.
        do_load(2, 32'h0000_0020, 32'h1234_5678, 32'h0);
        check("load_im_count", im_log.size() - im_base, 2);
        check("load_im0", im_log[im_base], {10'd0, 32'h0000_0020});
        check("load_im1", im_log[im_base + 1], {10'd4, 32'h1234_5678});
        check("load_ack", tx_log[tx_log.size() - 1], 8'h4B);

        // Zero-word load: acknowledgement only.
        do_load(0, 32'h0, 32'h0, 32'h0);
        check("load0_im_count", im_log.size() - im_base, 0);
        check("load0_tx_count", tx_log.size() - tx_base, 1);

        // Single step from reset.
        do_cmd(8'h53, 0, 1'b0);
        check("step_tx_count", tx_log.size() - tx_base, 136);
        check_count_field(32'h0000_0001);
        for (int i = 8; i < 12; i++) check("step_r0_byte", tx_log[tx_base + i], 8'h00);

        // Counter cleared, then a run that halts on its 10th enabled cycle.
        do_cmd(8'h52, 0, 1'b0);
        do_cmd(8'h43, 10, 1'b0);
        check_count_field(32'h0000_000A);
        do_cmd(8'h53, 1, 1'b0);
        check_count_field(32'h0000_000A);

        // Run without halt: stopped by the timeout, halted stays clear.
        do_cmd(8'h52, 0, 1'b0);
        do_cmd(8'h43, 0, 1'b1);
        check_count_field(32'h0000_0010);
        do_cmd(8'h53, 0, 1'b0);
        check_count_field(32'h0000_0011);

        // Reset in the middle of a dump.
        begin_cmd(0);
        m_cnt = sat_add(m_cnt, 1);
        push_dump(pc_base ^ pc_noise, m_cnt);
        send_byte(8'h53);
        g = 0;
        while ((tx_log.size() - tx_base) < 50 && g < 2000) begin
            @(negedge ClockIn);
            #1;
            g++;
        end
        if (g >= 2000) check("middump_timeout", tx_log.size() - tx_base, 50);
        Reset = 1'b1;
        @(negedge ClockIn);
        check_idle_outputs("middump");
        Reset = 1'b0;
        exp_tx.delete();
        m_cnt    = 32'd0;
        m_halted = 1'b0;
        idle(40);
        check("middump_bytes", tx_log.size() - tx_base, 50);
        end_cmd(1, 0);

        do_cmd(8'h52, 0, 1'b0);
        check("rst_ack", tx_log[tx_log.size() - 1], 8'h4B);
        do_cmd(8'h53, 0, 1'b0);
        check_count_field(32'h0000_0001);

        // Random command stream.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                do_load($urandom_range(0, 3), $urandom, $urandom, $urandom);
            end else if (r <= 4 || r == 9) begin
                do_cmd(8'h53, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end else if (r <= 6) begin
                do_cmd(8'h43, $urandom_range(0, 20), 1'($urandom_range(0, 1)));
            end else if (r == 7) begin
                do_cmd(8'h52, 0, 1'b0);
            end else begin
                do_cmd(8'h00 + 8'($urandom_range(0, 63)), 0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_debug_controller.md
Name: mips_debug_controller

Overview:
- UART-driven debug/sequencing controller for the 5-stage MIPS pipeline.
- Receives command bytes from the UART RX and performs one of:
  - load words into instruction memory;
  - run continuously until halt;
  - single-step one clock;
  - reset the CPU.
- After run or step, streams a state dump (PC, cycle count, 32 GPRs) to the UART TX.
- Sits between the UART byte interface and the MIPS top-level enable, instruction-memory write and register-file debug read ports.

Parameters:
- IM_ADDR_WIDTH, 10, width of the instruction-memory byte address; word writes land at word_index*4 modulo 2^IM_ADDR_WIDTH.
- RUN_TIMEOUT, 65535, maximum enabled cycles in continuous mode before a forced stop and dump.
- N_REGS, 32, number of GPRs in the dump.

Ports:
- ClockIn  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Rx_Data  in  8  received byte.
- Rx_Valid  in  1  one-cycle strobe; Rx_Data is valid.
- Tx_Busy  in  1  UART TX busy; rises the cycle after Tx_Start is accepted.
- Tx_Data  out  8  byte to transmit.
- Tx_Start  out  1  one-cycle transmit strobe.
- Halt  in  1  halt instruction reached WB.
- PC_In  in  32  current IF PC.
- Dbg_RegData  in  32  combinational register-file read data for Dbg_RegAddr.
- Dbg_RegAddr  out  5  register-file debug read address.
- CPU_Enable  out  1  pipeline clock enable; registers advance only when 1.
- CPU_Reset  out  1  one-cycle pipeline reset pulse.
- IM_WriteEnable  out  1  instruction-memory write strobe.
- IM_Address  out  IM_ADDR_WIDTH  instruction-memory byte address.
- IM_WriteData  out  32  instruction word.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; halted flag 0; cycle counter 0.
  - Reset in any state aborts the operation immediately; no partial dump resumes.
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, DUMP_SEND, DUMP_WAIT, ACK_SEND, ACK_WAIT, CPU_RST.
- IDLE dispatches on Rx_Valid:
  - 'L' (0x4C) -> LOAD_CNT.
  - 'C' (0x43) -> RUN, or DUMP_SEND if halted.
  - 'S' (0x53) -> STEP, or DUMP_SEND if halted.
  - 'R' (0x52) -> CPU_RST.
  - Any other byte is ignored.
- LOAD_CNT:
  - Next byte is word count N.
  - N=0 -> ACK_SEND.
  - Otherwise word index and byte counter are cleared -> LOAD_BYTE.
- LOAD_BYTE:
  - Shifts in 4 bytes, MSB first, into IM_WriteData -> LOAD_WR.
- LOAD_WR:
  - IM_WriteEnable=1 for exactly one cycle, with IM_Address=index*4 (wraps) and the assembled word.
  - Increments the index.
  - Index==N -> ACK_SEND, else LOAD_BYTE.
- ACK_SEND / ACK_WAIT: sends 0x4B ('K') using the TX handshake, then -> IDLE.
- RUN:
  - CPU_Enable=1 every cycle.
  - Cycle counter increments each enabled cycle, saturating at 0xFFFFFFFF.
  - Exit to DUMP_SEND on Halt=1 (sets halted; the cycle with Halt is counted), or when the run-local counter reaches RUN_TIMEOUT.
  - CPU_Enable drops the cycle after the exit.
- STEP:
  - CPU_Enable=1 for exactly one cycle; counter +1.
  - Halt in that cycle sets halted.
  - Then -> DUMP_SEND.
- CPU_RST:
  - CPU_Reset=1 for one cycle.
  - Clears halted and the cycle counter.
  - Then ACK.
- Dump:
  - 136 bytes, byte index b=0..135, MSB first within each word.
  - Words 0..1: PC_In, cycle counter. Words 2..33: GPR 0..31.
  - Dbg_RegAddr = (b>>2)-2 while b>=8.
  - PC_In and the counter are latched on dump entry, so the dump is stable.
- TX handshake:
  - DUMP_SEND/ACK_SEND assert Tx_Start only when Tx_Busy=0.
  - The *_WAIT states skip one cycle, then wait for Tx_Busy=0.
  - After the last byte (b=135) -> IDLE.
- Rx_Valid outside IDLE, LOAD_CNT and LOAD_BYTE is dropped.
- IM_WriteEnable and CPU_Enable are never asserted in the same cycle.

Test Plan:
- Reset, then 'L', 0x02, 00 00 00 20, 12 34 56 78 -> two one-cycle IM writes: addr 0 = 0x00000020, addr 4 = 0x12345678; then Tx byte 0x4B.
- 'L', 0x00 -> no IM write; single Tx 0x4B.
- 'S' after reset -> CPU_Enable high exactly 1 cycle; 136 Tx bytes; bytes 4..7 = 00 00 00 01; bytes 8..11 = 0 (R0).
- 'C' with Halt raised on the 10th enabled cycle -> CPU_Enable high 10 cycles; count field 0x0000000A; a following 'S' produces a dump with no enable pulse.
- 'C' with RUN_TIMEOUT=16 and Halt never asserted -> 16 enabled cycles, then dump with count 16; halted stays 0.
- Reset asserted mid-dump (b=50) -> Tx_Start stops; all outputs 0 next cycle; a later 'R' -> CPU_Reset pulse, count cleared, Tx 0x4B.
